// File: rtl/unidad_muldiv.sv
// -----------------------------------------------------------------------------
// unidad_muldiv -- iterative RV32M multiply/divide unit
//
// Sits between register-file read and write-back. It takes the two read-port
// operands, works one bit per cycle (radix-2) and returns the write-back data
// together with the destination index and write enable. Every operation takes
// the same number of cycles, including the divide special cases.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   operation request, sampled only in IDLE
//   funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,  111 REMU
//   a, b    in   rs1 / rs2 operand values
//   rd_in   in   destination register index
//   busy    out  high in CALC and FIN
//   done    out  one-cycle pulse, result valid
//   result  out  write-back data, held until the next FIN
//   rd_out  out  destination index, held until the next FIN
//   we_out  out  register-file write enable (done with a non-zero rd_out)
// -----------------------------------------------------------------------------
module unidad_muldiv #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [5:0]      cnt;
  logic [2:0]      op;
  logic [4:0]      rd_q;
  // Multiply: multiplicand |a|. Divide: divisor |b|.
  logic [XLEN-1:0] opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [W2-1:0]   acc;
  logic            neg;
  logic            divz;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    // a is signed for MUL, MULH, MULHSU, DIV, REM; b for MUL, MULH, DIV, REM.
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    mag_a    = sa ? (~a + 1'b1) : a;
    mag_b    = sb ? (~b + 1'b1) : b;
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply or restoring divide
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] rem_lo;
  logic [XLEN-1:0] sub;
  logic            ge;
  logic [W2-1:0]   acc_step;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sum      = '0;
    rem_lo   = '0;
    sub      = '0;
    ge       = 1'b0;
    acc_step = acc;
    if (!op[2]) begin
      sum      = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_step = {sum, acc[XLEN-1:1]};
    end else begin
      // The shifted partial remainder is 33 bits: {acc[63], rem_lo}. A set
      // top bit means it already exceeds any 32-bit divisor, and the true
      // difference then still fits in 32 bits, so modular subtraction is exact.
      rem_lo = {acc[W2-2:XLEN], acc[XLEN-1]};
      ge     = acc[W2-1] | (rem_lo >= opnd);
      sub    = rem_lo - opnd;
      acc_step = {(ge ? sub : rem_lo), acc[XLEN-2:0], ge};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign fix-up and result selection, from the last iteration's value
  // ---------------------------------------------------------------------------
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quo, rem, fin;

  always_comb begin
    prod_fix = neg ? (~acc_step + 1'b1) : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[W2-1:XLEN];
    unique case (op)
      3'b000:                 fin = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_fix[W2-1:XLEN];
      // Divide by zero forces all ones. The MIN/-1 overflow needs no override:
      // the magnitude quotient is 0x80000000 and negating it leaves it as is.
      3'b100, 3'b101:         fin = divz ? '1 : (neg ? (~quo + 1'b1) : quo);
      // A zero divisor leaves |a| as remainder; the sign fix-up restores a.
      default:                fin = neg ? (~rem + 1'b1) : rem;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state, including the datapath registers, is cleared on reset
    // so an aborted operation leaves nothing behind.
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      rd_q   <= '0;
      opnd   <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      divz   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            op    <= funct3;
            rd_q  <= rd_in;
            acc   <= funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd  <= funct3[2] ? mag_b : mag_a;
            // Remainders take the dividend's sign; everything else the XOR.
            neg   <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
            divz  <= (b == '0);
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITER - 1)) begin
            state  <= FIN;
            done   <= 1'b1;
            result <= fin;
            rd_out <= rd_q;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign we_out = done & (rd_out != 5'd0);

endmodule
